// File: rtl/div_unit.sv
// rtl/div_unit.sv - iterative radix-2 restoring divider for the EX stage
//
// Computes {remainder, quotient} for signed (DIV_OP) and unsigned (DIVU_OP)
// requests, one quotient bit per cycle, and holds the pipeline via stall_div.
//
// Ports:
//   clk        in   clock, rising edge
//   rst        in   synchronous active-high reset
//   alucontrol in   8-bit EX-stage ALU control code
//   valid      in   EX stage holds a live instruction
//   annul      in   flush of the EX instruction
//   opdata1    in   WIDTH dividend
//   opdata2    in   WIDTH divisor
//   result     out  2*WIDTH {hi = remainder, lo = quotient}
//   ready      out  one-cycle pulse, result valid this cycle
//   stall_div  out  hold PC, IF/ID and ID/EX this cycle

module div_unit #(
  parameter int         WIDTH   = 32,
  parameter logic [7:0] DIV_OP  = 8'b00011010,
  parameter logic [7:0] DIVU_OP = 8'b00011011
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [7:0]         alucontrol,
  input  logic               valid,
  input  logic               annul,
  input  logic [WIDTH-1:0]   opdata1,
  input  logic [WIDTH-1:0]   opdata2,
  output logic [2*WIDTH-1:0] result,
  output logic               ready,
  output logic               stall_div
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST_ITER = CW'(WIDTH - 1);

  typedef enum logic [1:0] {S_IDLE, S_ON, S_DZERO, S_END} state_t;

  state_t             state;
  logic [WIDTH-1:0]   rem;
  logic [WIDTH-1:0]   quo;
  logic [WIDTH-1:0]   dvs;
  logic [CW-1:0]      cnt;
  logic               sign1;
  logic               sign2;
  logic               sgn;
  logic [2*WIDTH-1:0] result_q;

  logic             is_div;
  logic             is_divu;
  logic             req;
  logic [WIDTH-1:0] abs1;
  logic [WIDTH-1:0] abs2;
  logic [WIDTH:0]   trial;
  logic [WIDTH-1:0] rem_nx;
  logic [WIDTH-1:0] quo_nx;
  logic [WIDTH-1:0] rem_fix;
  logic [WIDTH-1:0] quo_fix;

  assign is_div  = (alucontrol == DIV_OP);
  assign is_divu = (alucontrol == DIVU_OP);
  assign req     = valid & ~annul & (is_div | is_divu);

  // Magnitudes; -MIN wraps back to MIN, which is its correct unsigned magnitude.
  assign abs1 = (is_div && opdata1[WIDTH-1]) ? -opdata1 : opdata1;
  assign abs2 = (is_div && opdata2[WIDTH-1]) ? -opdata2 : opdata2;

  // The shifted partial remainder needs WIDTH+1 bits: with a divisor near
  // 2^WIDTH the shifted value can exceed WIDTH bits before the subtract.
  assign trial = {rem, quo[WIDTH-1]} - {1'b0, dvs};

  always_comb begin
    rem_nx = {rem[WIDTH-2:0], quo[WIDTH-1]};
    quo_nx = {quo[WIDTH-2:0], 1'b0};
    if (!trial[WIDTH]) begin
      rem_nx = trial[WIDTH-1:0];
      quo_nx = {quo[WIDTH-2:0], 1'b1};
    end
  end

  // Truncating division: quotient sign is the xor of operand signs,
  // remainder follows the dividend.
  assign quo_fix = (sgn && (sign1 ^ sign2)) ? -quo_nx : quo_nx;
  assign rem_fix = (sgn && sign1) ? -rem_nx : rem_nx;

  // An annulled END cycle neither pulses ready nor exposes the new result.
  assign ready     = (state == S_END) & ~annul;
  assign stall_div = req & ~ready;
  assign result    = ready ? {rem, quo} : result_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= S_IDLE;
      rem      <= '0;
      quo      <= '0;
      dvs      <= '0;
      cnt      <= '0;
      sign1    <= 1'b0;
      sign2    <= 1'b0;
      sgn      <= 1'b0;
      result_q <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (req) begin
            if (opdata2 == '0) begin
              state <= S_DZERO;
            end else begin
              rem   <= '0;
              quo   <= abs1;
              dvs   <= abs2;
              sign1 <= opdata1[WIDTH-1];
              sign2 <= opdata2[WIDTH-1];
              sgn   <= is_div;
              cnt   <= '0;
              state <= S_ON;
            end
          end
        end
        S_DZERO: begin
          if (annul) begin
            state <= S_IDLE;
          end else begin
            rem   <= '0;
            quo   <= '0;
            state <= S_END;
          end
        end
        S_ON: begin
          if (annul) begin
            state <= S_IDLE;
          end else if (cnt == LAST_ITER) begin
            rem   <= rem_fix;
            quo   <= quo_fix;
            cnt   <= cnt + 1'b1;
            state <= S_END;
          end else begin
            rem <= rem_nx;
            quo <= quo_nx;
            cnt <= cnt + 1'b1;
          end
        end
        S_END: begin
          if (!annul) begin
            result_q <= {rem, quo};
          end
          state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: doc/div_unit.md
Name: div_unit

Overview:
- Iterative 32-bit divider in the EX stage; consumes the 8-bit alucontrol code produced by the ALU decoder, alongside the ALU.
- Runs signed (`EXE_DIV_OP`) and unsigned (`EXE_DIVU_OP`) radix-2 restoring division, one quotient bit per cycle.
- Holds the EX stage through stall_div until the {remainder, quotient} pair is ready for the HI/LO write.
- Opcode macros come from defines.vh.

Parameters:
- WIDTH, 32, operand width; quotient and remainder are each WIDTH bits, result is 2*WIDTH bits.

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- rst  input  1  reset; synchronous, active-high.
- alucontrol  input  8  EX-stage ALU control code; only `EXE_DIV_OP` and `EXE_DIVU_OP` act on this block.
- valid  input  1  EX stage holds a live instruction.
- annul  input  1  flush of the EX instruction (exception or branch kill).
- opdata1  input  WIDTH  dividend (rs).
- opdata2  input  WIDTH  divisor (rt).
- result  output  2*WIDTH  {hi = remainder, lo = quotient}; registered.
- ready  output  1  one-cycle pulse: result is valid this cycle.
- stall_div  output  1  hold PC, IF/ID and ID/EX this cycle.

Behaviour:
- Reset (rst=1 at a clock edge): state=IDLE, result=0, ready=0, iteration counter=0, internal registers cleared. Applies mid-division: the division is abandoned and no ready pulse is produced.
- Request: req = valid & ~annul & (alucontrol==`EXE_DIV_OP` | alucontrol==`EXE_DIVU_OP`). Signed when alucontrol==`EXE_DIV_OP`.
- stall_div = req & ~ready. It is combinational and deasserts in the same cycle ready pulses.
- State IDLE, req=0: stay in IDLE; ready=0.
- State IDLE, req=1 and opdata2==0: go to DZERO.
- State IDLE, req=1 and opdata2!=0: latch |opdata1| and |opdata2| (absolute value when signed, raw value when unsigned). Also latch the signs and the signed flag, clear the partial remainder, set counter=0, go to ON.
- State DZERO: result <= 0; go to END.
- State ON, each cycle:
  - Shift {rem, quo} left by 1.
  - Trial-subtract the divisor using a WIDTH+1-bit subtract.
  - If the trial result is non-negative, commit it and set quotient bit 0 to 1.
  - counter++.
  - After the 32nd iteration (counter==31 at the edge), go to END.
- Sign fix-up, applied on entry to END, signed only:
  - Quotient is negated when the operand signs differ.
  - Remainder takes the dividend's sign.
- State END: ready=1 for exactly one cycle, result is valid; next state is IDLE unconditionally.
- Latency, request sampled in IDLE at edge T:
  - Nonzero divisor: ready high during cycle T+33.
  - Zero divisor: ready high during cycle T+2.
- annul=1 in ON, DZERO or END: go to IDLE next edge; ready is forced 0 that cycle; result is not updated.
- Back-to-back divides: the pipeline advances on the ready cycle. The IDLE cycle after END samples the next req, so there is one bubble cycle with stall_div=1.
- Operand changes while in ON are ignored; operands are sampled only in IDLE.
- result holds its last value until the next completed division.
- Signed 0x80000000 / 0xFFFFFFFF gives quotient 0x80000000, remainder 0; no trap.

Test Plan:
- Reset, then unsigned 100/7 (`EXE_DIVU_OP`, valid=1) -> stall_div=1 for 33 cycles; ready at T+33; result={32'd2, 32'd14}; stall_div=0 that cycle.
- Signed -7/2 (0xFFFFFFF9, 0x00000002, `EXE_DIV_OP`) -> result={0xFFFFFFFF, 0xFFFFFFFD}. Also 7/-2 -> {0x00000001, 0xFFFFFFFD}.
- Divide by zero: 0x12345678/0 -> ready at T+2; result=0.
- annul pulsed 10 cycles into ON -> no ready pulse; state IDLE next cycle; result unchanged. A new 0xFFFFFFFF/0x10 DIVU then yields {0x0000000F, 0x0FFFFFFF}.
- rst asserted mid-division -> result=0, ready=0 next cycle, stall_div follows req only. Non-divide alucontrol (`EXE_ADD_OP`) with valid=1 -> stall_div=0, state stays IDLE.
- Two back-to-back DIVs (0x80000000/0xFFFFFFFF, then 9/3) -> first {0, 0x80000000}; second {0, 3} with ready 34 cycles after the first ready.
